// File: rtl/sram_word_arbiter_if.sv
// Requester and SRAM port-A bundle for sram_word_arbiter.
// The arbiter uses the slave modport; requesters and the SRAM model sit on master.
interface sram_word_arbiter_if #(
  parameter int ADDRESS_BITS = 12
);
  logic                    req0Valid;
  logic                    req0Write;
  logic [ADDRESS_BITS-3:0] req0Address;
  logic [3:0]              req0ByteEnables;
  logic [31:0]             req0WriteData;
  logic [31:0]             req0ReadData;
  logic                    req0Done;

  logic                    req1Valid;
  logic                    req1Write;
  logic [ADDRESS_BITS-3:0] req1Address;
  logic [3:0]              req1ByteEnables;
  logic [31:0]             req1WriteData;
  logic [31:0]             req1ReadData;
  logic                    req1Done;

  logic                    busy;
  logic                    sramWriteEnable;
  logic [ADDRESS_BITS-1:0] sramAddress;
  logic [7:0]              sramWriteData;
  logic [7:0]              sramReadData;

  modport slave (
    input  req0Valid, req0Write, req0Address, req0ByteEnables, req0WriteData,
    output req0ReadData, req0Done,
    input  req1Valid, req1Write, req1Address, req1ByteEnables, req1WriteData,
    output req1ReadData, req1Done,
    output busy, sramWriteEnable, sramAddress, sramWriteData,
    input  sramReadData
  );

  modport master (
    output req0Valid, req0Write, req0Address, req0ByteEnables, req0WriteData,
    input  req0ReadData, req0Done,
    output req1Valid, req1Write, req1Address, req1ByteEnables, req1WriteData,
    input  req1ReadData, req1Done,
    input  busy, sramWriteEnable, sramAddress, sramWriteData,
    output sramReadData
  );
endinterface

// File: rtl/sram_word_arbiter.sv
// Arbitrates two 32-bit requesters onto one 8-bit SRAM port, turning each
// granted word access into four sequential byte accesses.
module sram_word_arbiter #(
  parameter int ADDRESS_BITS   = 12,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input logic                clock,
  input logic                reset,
  sram_word_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [1:0]              r_cnt;
  logic                    r_gnt;
  logic                    r_lastGrant;
  logic                    r_write;
  logic [ADDRESS_BITS-3:0] r_addr;
  logic [3:0]              r_be;
  logic [31:0]             r_wdata;
  logic [2:0][7:0]         r_rbuf;
  logic [31:0]             r_rdata0;
  logic [31:0]             r_rdata1;

  logic                    w_any_valid;
  logic                    w_sel;
  logic [1:0]              w_lane;
  logic [7:0]              w_byte;
  logic [31:0]             w_word;

  assign w_any_valid = bus.req0Valid | bus.req1Valid;
  // Requester 1 wins only when alone or when round-robin says it is its turn.
  assign w_sel = bus.req1Valid & (~bus.req0Valid | (!FIXED_PRIORITY & ~r_lastGrant));

  // Byte k of the word lives in lane k (little) or lane 3-k (big).
  assign w_word = BIG_ENDIAN ? {r_rbuf[0], r_rbuf[1], r_rbuf[2], bus.sramReadData}
                             : {bus.sramReadData, r_rbuf[2], r_rbuf[1], r_rbuf[0]};

  always_comb begin
    w_lane = BIG_ENDIAN ? (2'd3 - r_cnt) : r_cnt;
    unique case (w_lane)
      2'd0:    w_byte = r_wdata[7:0];
      2'd1:    w_byte = r_wdata[15:8];
      2'd2:    w_byte = r_wdata[23:16];
      default: w_byte = r_wdata[31:24];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:    if (w_any_valid) w_next_state = S_ACCESS;
      S_ACCESS:  if (r_cnt == 2'd3) w_next_state = r_write ? S_DONE : S_CAPTURE;
      S_CAPTURE: w_next_state = S_DONE;
      S_DONE:    w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt       <= '0;
      r_gnt       <= 1'b0;
      r_lastGrant <= 1'b1;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_rbuf      <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_gnt       <= w_sel;
            r_lastGrant <= w_sel;
            r_cnt       <= '0;
            r_write     <= w_sel ? bus.req1Write       : bus.req0Write;
            r_addr      <= w_sel ? bus.req1Address     : bus.req0Address;
            r_be        <= w_sel ? bus.req1ByteEnables : bus.req0ByteEnables;
            r_wdata     <= w_sel ? bus.req1WriteData   : bus.req0WriteData;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 2'd1;
          // SRAM output lags the address by one cycle: it carries byte cnt-1.
          if (!r_write) begin
            unique case (r_cnt)
              2'd1:    r_rbuf[0] <= bus.sramReadData;
              2'd2:    r_rbuf[1] <= bus.sramReadData;
              2'd3:    r_rbuf[2] <= bus.sramReadData;
              default: ;
            endcase
          end
        end
        S_CAPTURE: begin
          if (r_gnt) r_rdata1 <= w_word;
          else       r_rdata0 <= w_word;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy            = (r_state != S_IDLE);
    bus.sramWriteEnable = 1'b0;
    bus.sramAddress     = '0;
    bus.sramWriteData   = '0;
    if (r_state == S_ACCESS) begin
      bus.sramAddress     = {r_addr, r_cnt};
      bus.sramWriteData   = w_byte;
      // Gated by reset so a reset cycle never commits the byte in flight.
      bus.sramWriteEnable = r_write & r_be[r_cnt] & ~reset;
    end
    bus.req0Done = (r_state == S_DONE) & ~r_gnt;
    bus.req1Done = (r_state == S_DONE) &  r_gnt;
  end

  assign bus.req0ReadData = r_rdata0;
  assign bus.req1ReadData = r_rdata1;

endmodule

// File: tb/tb_sram_word_arbiter.sv
// Directed bench for sram_word_arbiter: one default instance and one
// big-endian fixed-priority instance, each with its own byte SRAM model.
module tb_sram_word_arbiter;

  logic clock = 1'b0;
  logic resetA = 1'b1;
  logic resetB = 1'b1;
  logic clearMem = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  sram_word_arbiter_if #(.ADDRESS_BITS(12)) busA ();
  sram_word_arbiter_if #(.ADDRESS_BITS(12)) busB ();

  sram_word_arbiter #(.ADDRESS_BITS(12), .BIG_ENDIAN(1'b0), .FIXED_PRIORITY(1'b0)) u_dutA (
    .clock(clock), .reset(resetA), .bus(busA)
  );
  sram_word_arbiter #(.ADDRESS_BITS(12), .BIG_ENDIAN(1'b1), .FIXED_PRIORITY(1'b1)) u_dutB (
    .clock(clock), .reset(resetB), .bus(busB)
  );

  logic [7:0] memA [4096];
  logic [7:0] memB [4096];

  always @(posedge clock) begin
    if (clearMem) begin
      for (int i = 0; i < 4096; i++) begin
        memA[i] <= 8'h00;
        memB[i] <= 8'h00;
      end
    end else begin
      if (busA.sramWriteEnable) memA[busA.sramAddress] <= busA.sramWriteData;
      if (busB.sramWriteEnable) memB[busB.sramAddress] <= busB.sramWriteData;
    end
    busA.sramReadData <= memA[busA.sramAddress];
    busB.sramReadData <= memB[busB.sramAddress];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction on instance A; inputs are dropped/scrambled right after grant.
  task automatic run_a(input bit r, input logic wr, input logic [9:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd,
                       output logic [3:0] weMask, output logic [11:0] maxAddr);
    int n;
    n = 0;
    while (busA.busy && n < 20) begin
      tick();
      n++;
    end
    lat = -1;
    rd = '0;
    weMask = '0;
    maxAddr = '0;
    if (!r) begin
      busA.req0Valid = 1'b1; busA.req0Write = wr; busA.req0Address = addr;
      busA.req0ByteEnables = be; busA.req0WriteData = wd;
    end else begin
      busA.req1Valid = 1'b1; busA.req1Write = wr; busA.req1Address = addr;
      busA.req1ByteEnables = be; busA.req1WriteData = wd;
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) begin
        busA.req0Valid = 1'b0; busA.req1Valid = 1'b0;
        busA.req0Write = ~wr; busA.req1Write = ~wr;
        busA.req0Address = ~addr; busA.req1Address = ~addr;
        busA.req0ByteEnables = ~be; busA.req1ByteEnables = ~be;
        busA.req0WriteData = ~wd; busA.req1WriteData = ~wd;
      end
      if (busA.sramWriteEnable) weMask[busA.sramAddress[1:0]] = 1'b1;
      if (busA.sramAddress > maxAddr) maxAddr = busA.sramAddress;
      if ((!r && busA.req0Done) || (r && busA.req1Done)) begin
        lat = c - 1;
        rd = r ? busA.req1ReadData : busA.req0ReadData;
        break;
      end
    end
  endtask

  int          lat;
  int          nd;
  int          n1;
  logic [31:0] rd;
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic [3:0]  weMask;
  logic [11:0] maxAddr;
  logic [3:0]  gseq;
  logic        seen;

  initial begin
    busA.req0Valid = 0; busA.req0Write = 0; busA.req0Address = '0; busA.req0ByteEnables = '0; busA.req0WriteData = '0;
    busA.req1Valid = 0; busA.req1Write = 0; busA.req1Address = '0; busA.req1ByteEnables = '0; busA.req1WriteData = '0;
    busB.req0Valid = 0; busB.req0Write = 0; busB.req0Address = '0; busB.req0ByteEnables = '0; busB.req0WriteData = '0;
    busB.req1Valid = 0; busB.req1Write = 0; busB.req1Address = '0; busB.req1ByteEnables = '0; busB.req1WriteData = '0;
    tick();
    tick();
    clearMem = 1'b0;

    // Reset state
    check("rst_ctrl", {28'd0, busA.busy, busA.sramWriteEnable, busA.req0Done, busA.req1Done}, 32'd0);
    check("rst_addr", {20'd0, busA.sramAddress}, 32'd0);
    check("rst_wdata", {24'd0, busA.sramWriteData}, 32'd0);
    check("rst_rdata0", busA.req0ReadData, 32'd0);
    check("rst_rdata1", busA.req1ReadData, 32'd0);
    resetA = 1'b0;
    resetB = 1'b0;
    tick();

    // Full write, then read by the other requester
    run_a(1'b0, 1'b1, 10'h005, 4'hF, 32'hA1B2C3D4, lat, rd, weMask, maxAddr);
    check("wr_latency", 32'(lat), 32'd4);
    check("wr_mem", {memA[12'h017], memA[12'h016], memA[12'h015], memA[12'h014]}, 32'hA1B2C3D4);
    check("wr_byte0", {24'd0, memA[12'h014]}, 32'h000000D4);
    run_a(1'b1, 1'b0, 10'h005, 4'h0, 32'h0, lat, rd, weMask, maxAddr);
    check("rd_latency", 32'(lat), 32'd5);
    check("rd_data", rd, 32'hA1B2C3D4);
    check("rd_other_untouched", busA.req0ReadData, 32'd0);

    // Partial write
    run_a(1'b0, 1'b1, 10'h005, 4'b0101, 32'h11223344, lat, rd, weMask, maxAddr);
    check("pw_we_mask", {28'd0, weMask}, 32'h5);
    run_a(1'b0, 1'b0, 10'h005, 4'hF, 32'h0, lat, rd, weMask, maxAddr);
    check("pw_read", rd, 32'hA122C344);
    check("pw_rd1_held", busA.req1ReadData, 32'hA1B2C3D4);

    // Top word of memory
    run_a(1'b1, 1'b1, 10'h3FF, 4'hF, 32'hCAFEF00D, lat, rd, weMask, maxAddr);
    check("bnd_max_addr", {20'd0, maxAddr}, 32'h00000FFF);
    check("bnd_mem", {memA[12'hFFF], memA[12'hFFE], memA[12'hFFD], memA[12'hFFC]}, 32'hCAFEF00D);
    check("bnd_no_wrap", {24'd0, memA[12'h000]}, 32'd0);
    run_a(1'b0, 1'b0, 10'h3FF, 4'h0, 32'h0, lat, rd, weMask, maxAddr);
    check("bnd_read", rd, 32'hCAFEF00D);

    // Round-robin tie from reset
    resetA = 1'b1;
    busA.req0Valid = 1; busA.req0Write = 0; busA.req0Address = 10'h005; busA.req0ByteEnables = 4'hF;
    busA.req1Valid = 1; busA.req1Write = 0; busA.req1Address = 10'h3FF; busA.req1ByteEnables = 4'hF;
    tick();
    tick();
    resetA = 1'b0;
    nd = 0; gseq = '0; rd0 = '0; rd1 = '0;
    for (int c = 0; c < 80 && nd < 4; c++) begin
      tick();
      if (busA.req0Done) begin gseq = {gseq[2:0], 1'b0}; nd++; rd0 = busA.req0ReadData; end
      if (busA.req1Done) begin gseq = {gseq[2:0], 1'b1}; nd++; rd1 = busA.req1ReadData; end
    end
    busA.req0Valid = 0;
    busA.req1Valid = 0;
    check("tie_count", 32'(nd), 32'd4);
    check("tie_order", {28'd0, gseq}, 32'b0101);
    check("tie_rd0", rd0, 32'hA122C344);
    check("tie_rd1", rd1, 32'hCAFEF00D);

    // Reset in the middle of a write
    run_a(1'b0, 1'b1, 10'h010, 4'hF, 32'h55667788, lat, rd, weMask, maxAddr);
    check("mr_setup", {memA[12'h043], memA[12'h042], memA[12'h041], memA[12'h040]}, 32'h55667788);
    tick();
    busA.req0Valid = 1; busA.req0Write = 1; busA.req0Address = 10'h010;
    busA.req0ByteEnables = 4'hF; busA.req0WriteData = 32'hAABBCCDD;
    tick();
    check("mr_busy", {31'd0, busA.busy}, 32'd1);
    tick();
    tick();
    check("mr_addr_cnt2", {20'd0, busA.sramAddress}, 32'h042);
    resetA = 1'b1;
    #1;
    check("mr_we_gated", {31'd0, busA.sramWriteEnable}, 32'd0);
    tick();
    check("mr_after_ctrl", {29'd0, busA.busy, busA.sramWriteEnable, busA.req0Done}, 32'd0);
    busA.req0Valid = 0;
    tick();
    check("mr_no_done", {31'd0, busA.req0Done}, 32'd0);
    resetA = 1'b0;
    tick();
    check("mr_mem", {memA[12'h043], memA[12'h042], memA[12'h041], memA[12'h040]}, 32'h5566CCDD);
    check("mr_rdata_cleared", busA.req0ReadData, 32'd0);

    // Big-endian write on instance B
    busB.req0Valid = 1; busB.req0Write = 1; busB.req0Address = 10'h005;
    busB.req0ByteEnables = 4'hF; busB.req0WriteData = 32'hA1B2C3D4;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (c == 1) busB.req0Valid = 0;
      if (busB.req0Done) seen = 1'b1;
    end
    check("be_wr_done", {31'd0, seen}, 32'd1);
    check("be_byte0", {24'd0, memB[12'h014]}, 32'h000000A1);
    check("be_mem", {memB[12'h017], memB[12'h016], memB[12'h015], memB[12'h014]}, 32'hD4C3B2A1);

    // Fixed priority tie on instance B
    resetB = 1'b1;
    busB.req0Valid = 1; busB.req0Write = 0; busB.req0Address = 10'h005; busB.req0ByteEnables = 4'hF;
    busB.req1Valid = 1; busB.req1Write = 0; busB.req1Address = 10'h005; busB.req1ByteEnables = 4'hF;
    tick();
    resetB = 1'b0;
    nd = 0; n1 = 0; rd0 = '0;
    for (int c = 0; c < 60 && nd < 3; c++) begin
      tick();
      if (busB.req0Done) begin nd++; rd0 = busB.req0ReadData; end
      if (busB.req1Done) n1++;
    end
    busB.req0Valid = 0;
    check("fp_req0_wins", 32'(nd), 32'd3);
    check("fp_req1_waits", 32'(n1), 32'd0);
    check("fp_rd0", rd0, 32'hA1B2C3D4);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (busB.req1Done) seen = 1'b1;
    end
    busB.req1Valid = 0;
    check("fp_req1_done", {31'd0, seen}, 32'd1);
    check("fp_rd1", busB.req1ReadData, 32'hA1B2C3D4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
